imem_loader: RTL and testbench

//  Byte-stream boot loader: writes a program image into the instruction memory of

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_loader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and imem write-port bundle for imem_loader.
// The slave modport is the loader side; master is the byte source / system side.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        reload;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_rst;
    logic        done;
    logic        err;

    modport master (
        output in_data, in_valid, reload,
        input  in_ready, mem_we, mem_addr, mem_wd, cpu_rst, done, err
    );

    modport slave (
        input  in_data, in_valid, reload,
        output in_ready, mem_we, mem_addr, mem_wd, cpu_rst, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a word count plus little-endian words over a byte stream,
// writes them into instruction memory, then releases the core from reset.
module imem_loader #(
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        StCnt0,
        StCnt1,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  byte_q, byte_d;
    // Bytes 0..2 of the word in flight; byte 3 goes straight into mem_wd.
    logic [23:0] asm_q, asm_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        in_ready;
    logic        xfer;
    logic [15:0] n_full;

    assign xfer   = bus.in_valid & in_ready;
    assign n_full = {bus.in_data, n_q[7:0]};

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StCnt0, StCnt1, StData: in_ready = 1'b1;
            default:                in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        asm_d      = asm_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        err_d      = err_q;

        if (bus.reload) begin
            state_d   = StCnt0;
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b0;
            idx_d     = 16'd0;
            byte_d    = 2'd0;
        end else begin
            unique case (state_q)
                StCnt0: begin
                    if (xfer) begin
                        n_d[7:0] = bus.in_data;
                        state_d  = StCnt1;
                    end
                end
                StCnt1: begin
                    if (xfer) begin
                        n_d = n_full;
                        if (n_full == 16'd0) begin
                            state_d   = StDone;
                            cpu_rst_d = 1'b0;
                            done_d    = 1'b1;
                        end else if (32'(n_full) > MEM_WORDS) begin
                            state_d = StErr;
                            err_d   = 1'b1;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        if (byte_q == 2'd3) begin
                            state_d    = StWrite;
                            byte_d     = 2'd0;
                            mem_we_d   = 1'b1;
                            mem_addr_d = BASE_ADDR + 32'({idx_q, 2'b00});
                            mem_wd_d   = {bus.in_data, asm_q};
                        end else begin
                            asm_d  = {bus.in_data, asm_q[23:8]};
                            byte_d = byte_q + 2'd1;
                        end
                    end
                end
                StWrite: begin
                    if (idx_q == n_q - 16'd1) begin
                        state_d   = StDone;
                        cpu_rst_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        state_d = StData;
                    end
                end
                StDone, StErr: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = StCnt0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StCnt0;
            n_q        <= 16'd0;
            idx_q      <= 16'd0;
            byte_q     <= 2'd0;
            asm_q      <= 24'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_wd_q   <= 32'd0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            byte_q     <= byte_d;
            asm_q      <= asm_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wd   = mem_wd_q;
    assign bus.cpu_rst  = cpu_rst_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, empty and oversize images,
// stalled stream, async reset mid-load and reload.
module tb_imem_loader;

    logic clk;
    logic rst;
    imem_loader_if bus ();

    imem_loader #(
        .MEM_WORDS (64),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Write log and imem model, captured at the edge that ends each mem_we cycle.
    int          wr_cnt = 0;
    logic [31:0] wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    logic [31:0] imem    [0:63];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            if (wr_cnt < 256) begin
                wr_addr[wr_cnt] = bus.mem_addr;
                wr_data[wr_cnt] = bus.mem_wd;
            end
            imem[bus.mem_addr[7:2]] = bus.mem_wd;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transferring edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic took;
        took = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 50 && !took; t++) begin
            took = bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!took) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
    endtask

    logic [7:0] s1 [10] = '{8'h02, 8'h00, 8'hef, 8'h00, 8'hc0, 8'h00,
                            8'h13, 8'h00, 8'h00, 8'h00};
    int base;

    initial begin
        rst          = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.reload   = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = 32'hdead_beef;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wd", bus.mem_wd, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Test 1: N=2, back-to-back bytes, exact write timing
        base = wr_cnt;
        for (int i = 0; i < 6; i++) send_byte(s1[i], 0);
        chk("t1_we_w0", 32'(bus.mem_we), 32'd1);
        chk("t1_addr_w0", bus.mem_addr, 32'h0000_0000);
        chk("t1_wd_w0", bus.mem_wd, 32'h00c0_00ef);
        chk("t1_ready_write", 32'(bus.in_ready), 32'd0);
        for (int i = 6; i < 10; i++) send_byte(s1[i], 0);
        chk("t1_we_w1", 32'(bus.mem_we), 32'd1);
        chk("t1_cpu_rst_in_write", 32'(bus.cpu_rst), 32'd1);
        chk("t1_done_in_write", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("t1_we_low", 32'(bus.mem_we), 32'd0);
        chk("t1_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_ready_done", 32'(bus.in_ready), 32'd0);
        chk("t1_addr_hold", bus.mem_addr, 32'h0000_0004);
        chk("t1_wd_hold", bus.mem_wd, 32'h0000_0013);
        chk("t1_nwrites", 32'(wr_cnt - base), 32'd2);
        chk("t1_w0_addr", wr_addr[base], 32'h0000_0000);
        chk("t1_w0_data", wr_data[base], 32'h00c0_00ef);
        chk("t1_w1_addr", wr_addr[base + 1], 32'h0000_0004);
        chk("t1_w1_data", wr_data[base + 1], 32'h0000_0013);

        // Test 6: reload, then a single-word image
        pulse_reload();
        chk("t6_cpu_rst_reload", 32'(bus.cpu_rst), 32'd1);
        chk("t6_done_reload", 32'(bus.done), 32'd0);
        chk("t6_ready_reload", 32'(bus.in_ready), 32'd1);
        base = wr_cnt;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hef, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("t6_nwrites", 32'(wr_cnt - base), 32'd1);
        chk("t6_imem0", imem[0], 32'h0000_00ef);
        chk("t6_imem1_kept", imem[1], 32'h0000_0013);
        chk("t6_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        chk("t6_done", 32'(bus.done), 32'd1);

        // Test 2: N=0
        pulse_reload();
        base = wr_cnt;
        send_byte(8'h00, 0);
        chk("t2_done_early", 32'(bus.done), 32'd0);
        send_byte(8'h00, 0);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        repeat (3) @(negedge clk);
        chk("t2_nwrites", 32'(wr_cnt - base), 32'd0);

        // Test 3: N=MEM_WORDS+1 rejected
        pulse_reload();
        base = wr_cnt;
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        chk("t3_err", 32'(bus.err), 32'd1);
        chk("t3_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("t3_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_done", 32'(bus.done), 32'd0);
        chk("t3_nwrites", 32'(wr_cnt - base), 32'd0);
        pulse_reload();
        chk("t3_err_cleared", 32'(bus.err), 32'd0);

        // Test 4: random gaps, byte 6 offered while the first word is written
        base = wr_cnt;
        for (int i = 0; i < 10; i++) send_byte(s1[i], (i == 6) ? 0 : int'($urandom_range(0, 3)));
        repeat (2) @(negedge clk);
        chk("t4_nwrites", 32'(wr_cnt - base), 32'd2);
        chk("t4_w0_addr", wr_addr[base], 32'h0000_0000);
        chk("t4_w0_data", wr_data[base], 32'h00c0_00ef);
        chk("t4_w1_addr", wr_addr[base + 1], 32'h0000_0004);
        chk("t4_w1_data", wr_data[base + 1], 32'h0000_0013);
        chk("t4_done", 32'(bus.done), 32'd1);

        // Test 5: async reset after 5 bytes, then the full stream
        pulse_reload();
        for (int i = 0; i < 5; i++) send_byte(s1[i], 0);
        rst = 1'b0;
        #1;
        chk("t5_addr_cleared", bus.mem_addr, 32'd0);
        chk("t5_wd_cleared", bus.mem_wd, 32'd0);
        chk("t5_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        base = wr_cnt;
        for (int i = 0; i < 10; i++) send_byte(s1[i], 0);
        @(negedge clk);
        chk("t5_nwrites", 32'(wr_cnt - base), 32'd2);
        chk("t5_w0_addr", wr_addr[base], 32'h0000_0000);
        chk("t5_w1_addr", wr_addr[base + 1], 32'h0000_0004);
        chk("t5_w1_data", wr_data[base + 1], 32'h0000_0013);
        chk("t5_done", 32'(bus.done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
